// File: rtl/glift_pkg.sv
// glift_pkg: shared constants, FSM state type and the conservative GLIFT add-taint rule.
package glift_pkg;
    localparam int ACC_W_DEF = 12;
    localparam int N_TERMS_DEF = 4;
    localparam int CNT_W_DEF = 4;
    localparam int TAINT_MAX_W = 32;

    typedef enum logic {ACC, HOLD} state_e;

    // A tainted operand bit can reach every higher sum bit through the carry chain.
    function automatic logic [TAINT_MAX_W-1:0] taint_add(
        input logic [TAINT_MAX_W-1:0] a_t,
        input logic [TAINT_MAX_W-1:0] b_t
    );
        logic [TAINT_MAX_W-1:0] x;
        logic [TAINT_MAX_W-1:0] r;
        x = a_t | b_t;
        r[0] = x[0];
        for (int i = 1; i < TAINT_MAX_W; i++) r[i] = r[i-1] | x[i];
        return r;
    endfunction
endpackage

// File: rtl/glift_taint_adder.sv
// glift_taint_adder: W-bit unsigned add with prefix-OR taint; optional saturation on carry-out.
module glift_taint_adder
    import glift_pkg::*;
#(
    parameter int W = 12,
    parameter bit SAT = 1'b0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] a_t_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] b_t_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] sum_t_o
);
    logic [W:0] s;
    logic [W-1:0] t;

    assign s = {1'b0, a_i} + {1'b0, b_i};
    assign t = W'(taint_add(TAINT_MAX_W'(a_t_i), TAINT_MAX_W'(b_t_i)));
    // t[W-1] is the OR of every operand taint bit, i.e. the carry-out taint.
    assign sum_o = (SAT && s[W]) ? {W{1'b1}} : s[W-1:0];
    assign sum_t_o = (SAT && s[W]) ? {W{t[W-1]}} : t;
endmodule

// File: rtl/glift_prod_acc.sv
// glift_prod_acc: block accumulator of N_TERMS tainted products with valid/ready in and out.
// Define GLIFT_ACC_SAT_EN to saturate on carry-out instead of wrapping.
module glift_prod_acc
    import glift_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       p,
    input  logic [7:0]       p_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] acc_t,
    output logic [CNT_W-1:0] cnt
);
`ifdef GLIFT_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e state_q;
    logic in_ready_q, out_valid_q;
    logic [ACC_W-1:0] acc_q, acc_t_q, acc_d, acc_t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    glift_taint_adder #(.W(ACC_W), .SAT(SAT_EN)) u_add (
        .a_i    (acc_q),
        .a_t_i  (acc_t_q),
        .b_i    ({{(ACC_W-8){1'b0}}, p}),
        .b_t_i  ({{(ACC_W-8){1'b0}}, p_t}),
        .sum_o  (acc_d),
        .sum_t_o(acc_t_d)
    );

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_t_q     <= '0;
            cnt_q       <= '0;
        end else if (state_q == ACC) begin
            if (in_valid) begin
                acc_q   <= acc_d;
                acc_t_q <= acc_t_d;
                cnt_q   <= cnt_d;
                if (cnt_d == CNT_W'(N_TERMS)) begin
                    state_q     <= HOLD;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
        end else if (out_ready) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_t_q     <= '0;
            cnt_q       <= '0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign acc_t     = acc_t_q;
    assign cnt       = cnt_q;
endmodule
